mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
- Streaming front end for the MAC datapath.
- Accepts one serial operand byte stream with a valid/ready/last handshake and deserializes it into (a, b, c) operand triples.
- Presents each triple on three parallel master operand buses under a single valid/ready handshake, ready to drive the MAC's a/b/c slave inputs.
- Flags short frames and counts delivered triples.

Parameters:
- Data_width, 8, width of every operand beat and operand bus.
- Cnt_width, 16, width of the delivered-triple counter.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  synchronous, active-low reset.
- s_data  input  Data_width  serial operand beat.
- s_valid  input  1  s_data valid.
- s_ready  output  1  sequencer accepts a beat this cycle.
- s_last  input  1  final beat of the frame.
- a_data  output  Data_width  operand a.
- b_data  output  Data_width  operand b.
- c_data  output  Data_width  operand c.
- m_valid  output  1  a/b/c triple valid.
- m_ready  input  1  downstream accepts the triple.
- m_last  output  1  the presented triple closes a frame.
- err_short  output  1  one-cycle pulse: a frame ended mid-triple.
- triple_cnt  output  Cnt_width  count of triples delivered.

Behaviour:
- Reset (aresetn low at a rising edge):
  - state = GET_A.
  - a_data, b_data, c_data, m_last, triple_cnt = 0.
  - m_valid = 0, err_short = 0.
  - s_ready = 1 from the first cycle after reset is released.
  - Reset mid-operation discards any partial or presented triple with no error pulse.
- Beat acceptance: a beat is accepted on a rising edge where s_valid and s_ready are both 1. Beat order within a triple is a, then b, then c.
- States:
  - GET_A: s_ready = 1. An accepted beat registers into a_data. If s_last = 0, go to GET_B. If s_last = 1, pulse err_short, discard the beat and stay in GET_A.
  - GET_B: s_ready = 1. An accepted beat registers into b_data. If s_last = 0, go to GET_C. If s_last = 1, pulse err_short, discard and go to GET_A.
  - GET_C: s_ready = 1. An accepted beat registers into c_data, m_last <= s_last, then go to PRESENT.
  - PRESENT: s_ready = 0 and m_valid = 1. a_data, b_data, c_data and m_last are held stable until m_ready = 1. On the handshake, triple_cnt increments, m_valid drops on the next cycle, and the state returns to GET_A.
- s_ready is a registered function of state only; it does not combinationally depend on m_ready or s_valid.
- m_valid is registered. It asserts the cycle after the c beat is accepted, giving one cycle of latency from c acceptance to m_valid.
- Throughput: at most one triple per 4 cycles (3 beats plus 1 presentation), with no bypass path.
- m_valid must never drop without a handshake.
- Idle cycles: s_valid = 0 in any GET state holds the state and the registers.
- err_short is exactly one cycle wide. It goes high in the cycle after the offending beat is accepted; that is its registered output.
- A frame whose length is a multiple of 3 produces no error; m_last = 1 only on the last triple.
- An a/b/c data register not yet overwritten keeps its previous value. Only m_valid qualifies the triple.
- triple_cnt wraps from 2^Cnt_width-1 to 0 without saturating or flagging.
- Backpressure: m_ready low for any number of cycles stalls in PRESENT. No input beat is accepted during the stall, so there is no loss and no duplication.
- Widths: no arithmetic on data; all buses are passed through at Data_width.

Test Plan:
- Reset, then beats 0x03, 0x05, 0x07 (last on 0x07) with m_ready = 1:
  - m_valid = 1 one cycle after 0x07 is accepted, with a = 0x03, b = 0x05, c = 0x07, m_last = 1.
  - triple_cnt = 1 after the handshake.
  - s_ready = 0 for exactly that PRESENT cycle.
- Two back-to-back triples (1, 2, 3) and (4, 5, 6) in one frame, s_valid held high:
  - Triples are delivered 4 cycles apart.
  - m_last = 0 on the first triple and 1 on the second; triple_cnt = 2.
- Frame 0x11, 0x22 with s_last on 0x22:
  - err_short pulses for exactly 1 cycle and m_valid never asserts.
  - The next beats 0x01, 0x02, 0x03 deliver a = 0x01, b = 0x02, c = 0x03.
- m_ready held low for 10 cycles in PRESENT while s_valid = 1 with data 0xAA:
  - a/b/c stay stable, s_ready stays 0 and no beat is consumed.
  - On m_ready = 1 the handshake completes, and 0xAA is then accepted as the next a.
- aresetn low for 1 cycle after beats a and b are accepted:
  - All outputs return to 0 and err_short stays 0.
  - The next three beats form a complete fresh triple.
- Cnt_width = 2 with 5 triples delivered: triple_cnt sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Serial operand front end for the MAC: gathers byte beats into (a, b, c)
// triples and presents them on three parallel buses under one handshake.
module mac_operand_sequencer #(
  parameter int Data_width = 8,
  parameter int Cnt_width  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [Data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [Data_width-1:0] a_data,
  output logic [Data_width-1:0] b_data,
  output logic [Data_width-1:0] c_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  err_short,
  output logic [Cnt_width-1:0]  triple_cnt
);

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    GET_C   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [Data_width-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  err_q, err_d;
  logic [Cnt_width-1:0]  cnt_q, cnt_d;
  logic                  beat_acc_s;

  assign beat_acc_s = s_valid && s_ready_q;

  // Next-state and registered-output computation; handshake flags derive from the next state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    m_last_d = m_last_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      GET_A: begin
        if (beat_acc_s) begin
          if (s_last) begin
            err_d = 1'b1;
          end else begin
            a_d     = s_data;
            state_d = GET_B;
          end
        end else begin
          state_d = GET_A;
        end
      end
      GET_B: begin
        if (beat_acc_s) begin
          if (s_last) begin
            err_d   = 1'b1;
            state_d = GET_A;
          end else begin
            b_d     = s_data;
            state_d = GET_C;
          end
        end else begin
          state_d = GET_B;
        end
      end
      GET_C: begin
        if (beat_acc_s) begin
          c_d      = s_data;
          m_last_d = s_last;
          state_d  = PRESENT;
        end else begin
          state_d = GET_C;
        end
      end
      PRESENT: begin
        if (m_ready) begin
          cnt_d   = cnt_q + {{(Cnt_width-1){1'b0}}, 1'b1};
          state_d = GET_A;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
    s_ready_d = (state_d != PRESENT);
    m_valid_d = (state_d == PRESENT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= GET_A;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign a_data     = a_q;
  assign b_data     = b_q;
  assign c_data     = c_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign err_short  = err_q;
  assign triple_cnt = cnt_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer: a frame-level model predicts
// triples and short-frame errors; a negedge monitor checks what the DUT presents.
module tb_mac_operand_sequencer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;

  logic        s_ready, m_valid, m_last, err_short;
  logic [7:0]  a_data, b_data, c_data;
  logic [15:0] triple_cnt;

  logic        s_ready2, m_valid2, m_last2, err_short2;
  logic [7:0]  a_data2, b_data2, c_data2;
  logic [1:0]  triple_cnt2;

  mac_operand_sequencer #(.Data_width(8), .Cnt_width(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .a_data(a_data), .b_data(b_data),
    .c_data(c_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .err_short(err_short), .triple_cnt(triple_cnt)
  );

  mac_operand_sequencer #(.Data_width(8), .Cnt_width(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready2), .s_last(s_last), .a_data(a_data2), .b_data(b_data2),
    .c_data(c_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
    .err_short(err_short2), .triple_cnt(triple_cnt2)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       last;
    int         k;
  } trip_t;

  trip_t      trip_q[$];
  int         err_q[$];
  logic [7:0] beat_buf[3];
  int         pos = 0;
  int         exp_cnt = 0;
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  int         mr_mode = 0;
  logic       mv_prev = 1'b0;
  logic       hs_prev = 1'b0;
  int         last_rise = 0;
  int         prev_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial forever begin
    @(posedge aclk);
    #1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      2:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Frame-level reference: every three beats make a triple, a frame ending early is an error.
  task automatic model_accept(input logic [7:0] d, input logic last, input int k);
    trip_t t;
    beat_buf[pos] = d;
    if (pos == 2) begin
      t.a = beat_buf[0]; t.b = beat_buf[1]; t.c = beat_buf[2];
      t.last = last; t.k = k;
      trip_q.push_back(t);
      pos = 0;
    end else if (last) begin
      err_q.push_back(k);
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been taken.
  task automatic send_beat(input logic [7:0] d, input logic last, input int idle);
    logic acc;
    int   t;
    s_valid = 1'b0;
    repeat (idle) begin
      @(posedge aclk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    acc = 1'b0;
    for (t = 0; t < 200 && !acc; t++) begin
      @(negedge aclk);
      acc = s_ready;
      @(posedge aclk);
      #1;
    end
    if (acc) model_accept(d, last, cyc);
    else chk("beat_accept_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    pos = 0;
    exp_cnt = 0;
    trip_q.delete();
    err_q.delete();
    chk("rst_a", 32'(a_data), 32'd0);
    chk("rst_b", 32'(b_data), 32'd0);
    chk("rst_c", 32'(c_data), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_err", 32'(err_short), 32'd0);
    chk("rst_cnt", 32'(triple_cnt), 32'd0);
    chk("rst_cnt_w2", 32'(triple_cnt2), 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (trip_q.size() > 0 || err_q.size() > 0); t++) begin
      @(posedge aclk);
      #1;
    end
    chk("drain_triples", 32'(trip_q.size()), 32'd0);
    chk("drain_errors", 32'(err_q.size()), 32'd0);
  endtask

  // Monitor: compares presented triples, error pulses, s_ready and the counters.
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      mv_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (err_short) begin
        if (err_q.size() == 0) chk("err_spurious", 32'(err_short), 32'd0);
        else chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        chk("err_missing", 32'(err_short), 32'd1);
        void'(err_q.pop_front());
      end
      if (hs_prev) begin
        chk("triple_cnt", 32'(triple_cnt), 32'(exp_cnt & 32'hFFFF));
        chk("triple_cnt_w2", 32'(triple_cnt2), 32'(exp_cnt & 32'h3));
        chk("m_valid_after_hs", 32'(m_valid), 32'd0);
      end
      if (m_valid) begin
        chk("s_ready_in_present", 32'(s_ready), 32'd0);
        if (trip_q.size() == 0) begin
          chk("m_valid_spurious", 32'(m_valid), 32'd0);
        end else begin
          if (!mv_prev) begin
            chk("m_valid_latency", 32'(cyc), 32'(trip_q[0].k));
            prev_rise = last_rise;
            last_rise = cyc;
          end
          chk("a_data", 32'(a_data), 32'(trip_q[0].a));
          chk("b_data", 32'(b_data), 32'(trip_q[0].b));
          chk("c_data", 32'(c_data), 32'(trip_q[0].c));
          chk("m_last", 32'(m_last), 32'(trip_q[0].last));
        end
      end else begin
        chk("s_ready_idle", 32'(s_ready), 32'd1);
        if (mv_prev && !hs_prev) chk("m_valid_dropped", 32'(m_valid), 32'd1);
        if (trip_q.size() > 0 && trip_q[0].k <= cyc) begin
          chk("m_valid_missing", 32'(m_valid), 32'd1);
          void'(trip_q.pop_front());
        end
      end
      hs_prev = m_valid && m_ready && (trip_q.size() > 0);
      if (hs_prev) begin
        void'(trip_q.pop_front());
        exp_cnt++;
      end
      mv_prev = m_valid;
    end
  end

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    do_reset();
    @(posedge aclk);
    #1;

    mr_mode = 0;
    send_beat(8'h03, 1'b0, 0);
    send_beat(8'h05, 1'b0, 0);
    send_beat(8'h07, 1'b1, 0);
    drain();

    for (int i = 1; i <= 6; i++) send_beat(8'(i), (i == 6), 0);
    drain();
    chk("back_to_back_spacing", 32'(last_rise - prev_rise), 32'd4);

    send_beat(8'h11, 1'b0, 0);
    send_beat(8'h22, 1'b1, 0);
    send_beat(8'h99, 1'b1, 1);
    send_beat(8'h01, 1'b0, 0);
    send_beat(8'h02, 1'b0, 0);
    send_beat(8'h03, 1'b1, 0);
    drain();

    mr_mode = 2;
    send_beat(8'h10, 1'b0, 0);
    send_beat(8'h20, 1'b0, 0);
    send_beat(8'h30, 1'b0, 0);
    fork
      begin
        send_beat(8'hAA, 1'b0, 0);
        send_beat(8'hBB, 1'b0, 0);
        send_beat(8'hCC, 1'b1, 0);
      end
      begin
        repeat (10) @(negedge aclk);
        mr_mode = 0;
      end
    join
    drain();

    send_beat(8'h40, 1'b0, 0);
    send_beat(8'h41, 1'b0, 0);
    do_reset();
    send_beat(8'h50, 1'b0, 0);
    send_beat(8'h51, 1'b0, 0);
    send_beat(8'h52, 1'b1, 0);
    drain();

    mr_mode = 1;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        send_beat(8'($urandom), (i == len - 1), $urandom_range(0, 2));
    end
    drain();
    mr_mode = 0;
    repeat (3) @(posedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
